// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds or subtracts two WORDS x 32-bit operands by stepping a single
//   32-bit tree-carry adder over the words. It works least-significant word
//   first, one word per clock, and holds the inter-word carry in a register.
//
//   Parameters:
//     WORDS      number of 32-bit words per operand (2..16)
//   Ports:
//     clk        system clock, rising edge
//     reset      synchronous active-high reset
//     start      request, sampled only while idle
//     sub        0 = a+b, 1 = a-b, captured with start
//     a_in/b_in  operands, captured with start
//     busy       high while the operation runs and during the done cycle
//     done       one-cycle pulse when result is valid
//     result     sum/difference, held until overwritten by the next op
//     carry_out  final carry (for sub: 1 = no borrow)
//     overflow   signed overflow of the full-width op
//                (present only with MULTIWORD_ADD_OVERFLOW_EN)
//
//   Optional build macro: MULTIWORD_ADD_OVERFLOW_EN

// 32-bit adder with a parallel-prefix (Kogge-Stone) carry tree.
module fulladder_with_tree_carry_32 (
    output logic [31:0] sum,
    output logic        carry_out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in
);
    logic [31:0] p0;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] gn;
    logic [31:0] pn;

    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        // Fold carry_in into bit 0 so that g[i] becomes the carry out of bit i.
        g[0] = g[0] | (p0[0] & carry_in);
        for (int l = 0; l < 5; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < 32; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        sum       = p0 ^ {g[30:0], carry_in};
        carry_out = g[31];
    end
endmodule

module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sub,
    input  logic [32*WORDS-1:0] a_in,
    input  logic [32*WORDS-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic [32*WORDS-1:0] result,
`ifdef MULTIWORD_ADD_OVERFLOW_EN
    output logic               overflow,
`endif
    output logic               carry_out
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    sub_q, sub_d;
    logic [WORDS-1:0][31:0]  a_q, a_d;
    logic [WORDS-1:0][31:0]  b_q, b_d;
    logic [WORDS-1:0][31:0]  result_q, result_d;
    logic                    cout_q, cout_d;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
    logic                    ovf_q, ovf_d;
`endif

    logic [31:0] add_a, add_b, add_sum;
    logic        add_co;

    // Subtraction feeds ~B and seeds the carry with 1 (a + ~b + 1).
    assign add_a = a_q[idx_q];
    assign add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];

    fulladder_with_tree_carry_32 u_adder (
        .sum       (add_sum),
        .carry_out (add_co),
        .a         (add_a),
        .b         (add_b),
        .carry_in  (carry_q)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                result_d[idx_q] = add_sum;
                carry_d         = add_co;
                if (idx_q == LAST_IDX) begin
                    // Reset the index rather than incrementing, so it never
                    // wraps when WORDS is a power of two.
                    idx_d   = '0;
                    cout_d  = add_co;
                    state_d = DONE;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
                    // Carry into the MSB is recovered from the sum bit.
                    ovf_d   = (add_sum[31] ^ add_a[31] ^ add_b[31]) ^ add_co;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
`ifdef MULTIWORD_ADD_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif
endmodule
